rf_access_arbiter: RTL and testbench
====================================

Name: rf_access_arbiter

Overview:
- Shares the 8-bit register file (4 R + 4 T registers, dual read ports O1/O2, shared write input) between two requesters, A and B.
- Each requester issues one RF command per handshake: read selects, function select, R/T enables and write data.
- The arbiter grants one command per cycle by round-robin and drives the RF control pins from registers.
- It returns the two RF read-port values to the issuing requester after a fixed 2-cycle latency.

Parameters:
- DATA_W, 8, width of RF data (write data, O1/O2, response data).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A command valid.
- a_ready  out  1  A command accepted this cycle (combinational).
- a_o1sel, a_o2sel  in  3 each  A read selects.
- a_funsel  in  2  A function select.
- a_rsel, a_tsel  in  4 each  A R/T enables.
- a_wdata  in  DATA_W  A write data.
- b_valid, b_ready, b_o1sel, b_o2sel, b_funsel, b_rsel, b_tsel, b_wdata: same widths and meanings for requester B.
- rf_o1sel, rf_o2sel  out  3 each  registered RF read selects.
- rf_funsel  out  2  registered RF FunSel.
- rf_rsel, rf_tsel  out  4 each  registered RF enables.
- rf_i  out  DATA_W  registered RF write data.
- rf_o1, rf_o2  in  DATA_W  RF read outputs.
- rsp_a_valid, rsp_b_valid  out  1  response strobe per requester.
- rsp_o1, rsp_o2  out  DATA_W  response data, shared by both requesters.

Behaviour:
- Reset (async, rst=1):
  - all rf_* outputs = 0, so rf_rsel = rf_tsel = 0 and no register is enabled;
  - rsp_*_valid = 0, rsp_o1 = rsp_o2 = 0;
  - pipeline tags cleared; round-robin pointer set to favour A.
- Arbitration (combinational):
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted most recently wins.
  - The pointer updates only on an accepted command.
  - a_ready/b_ready are high only for the winner; at most one ready per cycle.
  - The ready signals never depend on the ready outputs themselves.
- Issue:
  - On a posedge with valid&ready, the winner's fields are registered onto rf_*.
  - On a posedge with no acceptance, rf_rsel = rf_tsel = 0 (no writes). Selects, funsel and rf_i hold their last values.
- Pipeline:
  - The RF samples rf_* at the edge after issue (E+1); rf_o1/rf_o2 are valid after E+1.
  - The arbiter registers rf_o1/rf_o2 into rsp_o1/rsp_o2 at E+2.
  - The matching rsp_x_valid is high for exactly the one cycle following E+2.
  - A 2-stage tag shift register (valid + owner bit) tracks in-flight commands.
  - Latency = 2 edges from acceptance. Throughput = 1 command per cycle.
- Responses:
  - No backpressure; requesters must accept responses.
  - rsp_o1/rsp_o2 hold their value when no response is valid.
  - A read issued the cycle after a write to the same register returns the written value. The arbiter does no hazard tracking; order equals issue order.
- Commands with rsel = tsel = 0 are pure reads and are still accepted and responded to.
- Reset mid-operation: in-flight responses are dropped (no rsp_valid after reset release). The first command after release needs a full 2 cycles.

Optional Feature:
- Macro: RF_ARB_LOCK_EN.
- With the macro defined:
  - Adds inputs a_lock and b_lock (1 bit each).
  - A command accepted with lock=1 makes that requester the sole eligible winner on following cycles until it is accepted with lock=0 or drops valid.
  - While locked, the other requester's ready stays 0.
  - This gives atomic multi-cycle RF sequences, such as read-modify-write.
  - Reset clears the lock.
- Without the macro: the lock ports do not exist and arbitration is pure round-robin.

Test Plan:
- Reset release, A issues rsel=4'b1000, funsel=2'b01, wdata=8'h5A, then A read o1sel=3'b100 -> rsp_a_valid 2 cycles after the read accept, rsp_o1=8'h5A; rf_rsel=0 on idle cycles.
- A and B valid continuously -> grants alternate A,B,A,B starting with A; rsp_a_valid and rsp_b_valid alternate 2 cycles behind the grants.
- Only B valid for 4 cycles -> b_ready high every cycle, 4 back-to-back rsp_b_valid pulses, a_ready=0 throughout.
- B writes R2=8'h33 and the next cycle A reads o2sel=3'b101 -> A's rsp_o2=8'h33.
- rst pulsed while 2 commands are in flight -> no rsp_*_valid after release, rf_rsel=rf_tsel=0, next grant goes to A.
- RF_ARB_LOCK_EN defined, A holds lock for 3 commands with B valid throughout -> b_ready=0 for those 3 cycles, B granted on the cycle after A's lock=0 command.

Source files
------------

// File: rtl/rf_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_access_arbiter_if
// Bundles the two requester command channels, the register-file control and
// read pins, and the response channel of rf_access_arbiter.
//   slave  : arbiter side
//   master : environment side (requesters + register file)
// Optional lock inputs exist only when RF_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
interface rf_access_arbiter_if #(
    parameter int DATA_W = 8
);
    // Requester A command channel
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_o1sel;
    logic [2:0]        a_o2sel;
    logic [1:0]        a_funsel;
    logic [3:0]        a_rsel;
    logic [3:0]        a_tsel;
    logic [DATA_W-1:0] a_wdata;

    // Requester B command channel
    logic              b_valid;
    logic              b_ready;
    logic [2:0]        b_o1sel;
    logic [2:0]        b_o2sel;
    logic [1:0]        b_funsel;
    logic [3:0]        b_rsel;
    logic [3:0]        b_tsel;
    logic [DATA_W-1:0] b_wdata;

`ifdef RF_ARB_LOCK_EN
    logic              a_lock;
    logic              b_lock;
`endif

    // Register-file control and read pins
    logic [2:0]        rf_o1sel;
    logic [2:0]        rf_o2sel;
    logic [1:0]        rf_funsel;
    logic [3:0]        rf_rsel;
    logic [3:0]        rf_tsel;
    logic [DATA_W-1:0] rf_i;
    logic [DATA_W-1:0] rf_o1;
    logic [DATA_W-1:0] rf_o2;

    // Response channel
    logic              rsp_a_valid;
    logic              rsp_b_valid;
    logic [DATA_W-1:0] rsp_o1;
    logic [DATA_W-1:0] rsp_o2;

    modport slave (
`ifdef RF_ARB_LOCK_EN
        input  a_lock, b_lock,
`endif
        input  a_valid, a_o1sel, a_o2sel, a_funsel, a_rsel, a_tsel, a_wdata,
        output a_ready,
        input  b_valid, b_o1sel, b_o2sel, b_funsel, b_rsel, b_tsel, b_wdata,
        output b_ready,
        output rf_o1sel, rf_o2sel, rf_funsel, rf_rsel, rf_tsel, rf_i,
        input  rf_o1, rf_o2,
        output rsp_a_valid, rsp_b_valid, rsp_o1, rsp_o2
    );

    modport master (
`ifdef RF_ARB_LOCK_EN
        output a_lock, b_lock,
`endif
        output a_valid, a_o1sel, a_o2sel, a_funsel, a_rsel, a_tsel, a_wdata,
        input  a_ready,
        output b_valid, b_o1sel, b_o2sel, b_funsel, b_rsel, b_tsel, b_wdata,
        input  b_ready,
        input  rf_o1sel, rf_o2sel, rf_funsel, rf_rsel, rf_tsel, rf_i,
        output rf_o1, rf_o2,
        input  rsp_a_valid, rsp_b_valid, rsp_o1, rsp_o2
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// rf_access_arbiter
// Shares one register file between requesters A and B. One command is granted
// per cycle (round-robin), its fields are registered onto the RF pins, and the
// two RF read values come back to the issuing requester two edges after
// acceptance.
// Optional feature: define RF_ARB_LOCK_EN to add a_lock/b_lock, letting a
// requester hold exclusive access across consecutive commands.
// ---------------------------------------------------------------------------
module rf_access_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    rf_access_arbiter_if.slave  bus
);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    owner_e            last_q;      // requester granted most recently
    logic              rr_a;
    logic              rr_b;
    logic              grant_a;
    logic              grant_b;
    logic              accept;

    logic [2:0]        rf_o1sel_q;
    logic [2:0]        rf_o2sel_q;
    logic [1:0]        rf_funsel_q;
    logic [3:0]        rf_rsel_q;
    logic [3:0]        rf_tsel_q;
    logic [DATA_W-1:0] rf_i_q;

    tag_t              tag1_q;      // issued, RF sampling next edge
    tag_t              tag2_q;      // RF outputs valid, capture next edge
    logic              rsp_a_valid_q;
    logic              rsp_b_valid_q;
    logic [DATA_W-1:0] rsp_o1_q;
    logic [DATA_W-1:0] rsp_o2_q;

`ifdef RF_ARB_LOCK_EN
    logic              lock_a_q;
    logic              lock_b_q;
`endif

    // Round-robin choice: a lone requester wins, a tie goes to the one not
    // granted last. Depends only on valids and the pointer, never on ready.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which is what would otherwise infer a latch.
        rr_a = 1'b0;
        rr_b = 1'b0;
        if (bus.a_valid && (!bus.b_valid || last_q == OWN_B)) begin
            rr_a = 1'b1;
        end else if (bus.b_valid) begin
            rr_b = 1'b1;
        end
    end

`ifdef RF_ARB_LOCK_EN
    // A live lock makes its owner the only eligible winner while it stays valid.
    always_comb begin
        grant_a = rr_a;
        grant_b = rr_b;
        if (lock_a_q && bus.a_valid) begin
            grant_a = 1'b1;
            grant_b = 1'b0;
        end else if (lock_b_q && bus.b_valid) begin
            grant_a = 1'b0;
            grant_b = 1'b1;
        end
    end

    // Lock follows the lock bit of each accepted command; dropping valid releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_a_q <= 1'b0;
            lock_b_q <= 1'b0;
        end else begin
            if (grant_a) begin
                lock_a_q <= bus.a_lock;
            end else if (grant_b || !bus.a_valid) begin
                lock_a_q <= 1'b0;
            end
            if (grant_b) begin
                lock_b_q <= bus.b_lock;
            end else if (grant_a || !bus.b_valid) begin
                lock_b_q <= 1'b0;
            end
        end
    end
`else
    // Without locking the round-robin choice is the grant.
    always_comb begin
        grant_a = rr_a;
        grant_b = rr_b;
    end
`endif

    assign accept      = grant_a || grant_b;
    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    // Pointer moves only when a command is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWN_B;            // favours A after reset
        end else if (accept) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            last_q <= grant_a ? OWN_A : OWN_B;
        end
    end

    // Issue stage: winner's fields onto the RF pins; idle cycles disable writes
    // while selects, funsel and write data keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_o1sel_q  <= '0;
            rf_o2sel_q  <= '0;
            rf_funsel_q <= '0;
            rf_rsel_q   <= '0;
            rf_tsel_q   <= '0;
            rf_i_q      <= '0;
        end else if (accept) begin
            rf_o1sel_q  <= grant_a ? bus.a_o1sel  : bus.b_o1sel;
            rf_o2sel_q  <= grant_a ? bus.a_o2sel  : bus.b_o2sel;
            rf_funsel_q <= grant_a ? bus.a_funsel : bus.b_funsel;
            rf_rsel_q   <= grant_a ? bus.a_rsel   : bus.b_rsel;
            rf_tsel_q   <= grant_a ? bus.a_tsel   : bus.b_tsel;
            rf_i_q      <= grant_a ? bus.a_wdata  : bus.b_wdata;
        end else begin
            rf_rsel_q   <= '0;
            rf_tsel_q   <= '0;
        end
    end

    // Two-stage tag pipeline tracking which requester owns each in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag1_q <= '0;
            tag2_q <= '0;
        end else begin
            tag1_q <= '{valid: accept, owner: (grant_b ? OWN_B : OWN_A)};
            tag2_q <= tag1_q;
        end
    end

    // Response stage: capture RF outputs for the owning requester, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_a_valid_q <= 1'b0;
            rsp_b_valid_q <= 1'b0;
            rsp_o1_q      <= '0;
            rsp_o2_q      <= '0;
        end else begin
            rsp_a_valid_q <= tag2_q.valid && (tag2_q.owner == OWN_A);
            rsp_b_valid_q <= tag2_q.valid && (tag2_q.owner == OWN_B);
            if (tag2_q.valid) begin
                rsp_o1_q <= bus.rf_o1;
                rsp_o2_q <= bus.rf_o2;
            end
        end
    end

    assign bus.rf_o1sel    = rf_o1sel_q;
    assign bus.rf_o2sel    = rf_o2sel_q;
    assign bus.rf_funsel   = rf_funsel_q;
    assign bus.rf_rsel     = rf_rsel_q;
    assign bus.rf_tsel     = rf_tsel_q;
    assign bus.rf_i        = rf_i_q;
    assign bus.rsp_a_valid = rsp_a_valid_q;
    assign bus.rsp_b_valid = rsp_b_valid_q;
    assign bus.rsp_o1      = rsp_o1_q;
    assign bus.rsp_o2      = rsp_o2_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_access_arbiter
// Drives directed command vectors into rf_access_arbiter, models the register
// file it controls, and compares every cycle against a transaction-level
// model of arbitration, RF contents and response timing. Lock scenario is
// included when RF_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_rf_access_arbiter;

    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rf_access_arbiter_if #(.DATA_W(DATA_W)) bus();

    rf_access_arbiter #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FunSel: 00 clear, 01 load, 10 increment, 11 decrement
    function automatic logic [7:0] apply_fun(input logic [1:0] f, input logic [7:0] v,
                                             input logic [7:0] d);
        case (f)
            2'b00:   return 8'h00;
            2'b01:   return d;
            2'b10:   return v + 8'h01;
            default: return v - 8'h01;
        endcase
    endfunction

    // Register file: index 0..3 = T1..T4, 4..7 = R1..R4; enable bit 3 = reg 1.
    // Registered read ports sample the selects on the same edge as writes.
    logic [7:0] rf_regs [8] = '{default: 8'h00};
    logic [7:0] rf_o1_q = 8'h00;
    logic [7:0] rf_o2_q = 8'h00;

    always @(posedge clk) begin
        rf_o1_q <= rf_regs[bus.rf_o1sel];
        rf_o2_q <= rf_regs[bus.rf_o2sel];
        for (int k = 0; k < 4; k++) begin
            if (bus.rf_rsel[3-k]) rf_regs[4+k] <= apply_fun(bus.rf_funsel, rf_regs[4+k], bus.rf_i);
            if (bus.rf_tsel[3-k]) rf_regs[k]   <= apply_fun(bus.rf_funsel, rf_regs[k], bus.rf_i);
        end
    end
    assign bus.rf_o1 = rf_o1_q;
    assign bus.rf_o2 = rf_o2_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int         due;
        bit         own_b;
        logic [7:0] o1;
        logic [7:0] o2;
    } exp_rsp_t;

    exp_rsp_t   rq[$];
    int         win_log[$];     // model winner per accepted command (0=A, 1=B)
    int         rsp_log[$];     // DUT response owners as observed
    logic [7:0] sb_regs [8] = '{default: 8'h00};
    bit         last_b = 1'b1;
    int         lock_own = -1;
    logic [2:0] e_o1sel, e_o2sel;
    logic [1:0] e_fun;
    logic [3:0] e_rsel, e_tsel;
    logic [7:0] e_i, exp_o1, exp_o2;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rq.delete();
                last_b = 1'b1; lock_own = -1;
                e_o1sel = '0; e_o2sel = '0; e_fun = '0; e_rsel = '0; e_tsel = '0; e_i = '0;
                exp_o1 = '0; exp_o2 = '0;
                check("reset rf_rsel", bus.rf_rsel, 0);
                check("reset rf_tsel", bus.rf_tsel, 0);
                check("reset rf_i", bus.rf_i, 0);
                check("reset rsp_a_valid", bus.rsp_a_valid, 0);
                check("reset rsp_b_valid", bus.rsp_b_valid, 0);
                check("reset rsp_o1", bus.rsp_o1, 0);
            end else begin
                bit  due, av, bv, lk;
                int  w;
                logic [2:0] s1, s2;
                logic [1:0] f;
                logic [3:0] rs, ts;
                logic [7:0] wd;

                check("rf_o1sel", bus.rf_o1sel, e_o1sel);
                check("rf_o2sel", bus.rf_o2sel, e_o2sel);
                check("rf_funsel", bus.rf_funsel, e_fun);
                check("rf_rsel", bus.rf_rsel, e_rsel);
                check("rf_tsel", bus.rf_tsel, e_tsel);
                check("rf_i", bus.rf_i, e_i);

                due = (rq.size() > 0) && (rq[0].due == cyc);
                check("rsp_a_valid", bus.rsp_a_valid, due && !rq[0].own_b);
                check("rsp_b_valid", bus.rsp_b_valid, due && rq[0].own_b);
                if (due) begin
                    exp_o1 = rq[0].o1;
                    exp_o2 = rq[0].o2;
                    void'(rq.pop_front());
                end
                check("rsp_o1", bus.rsp_o1, exp_o1);
                check("rsp_o2", bus.rsp_o2, exp_o2);
                if (bus.rsp_a_valid) rsp_log.push_back(0);
                if (bus.rsp_b_valid) rsp_log.push_back(1);

                av = bus.a_valid;
                bv = bus.b_valid;
                if      (lock_own == 0 && av) w = 0;
                else if (lock_own == 1 && bv) w = 1;
                else if (av && bv)            w = last_b ? 0 : 1;
                else if (av)                  w = 0;
                else if (bv)                  w = 1;
                else                          w = -1;
                check("a_ready", bus.a_ready, w == 0);
                check("b_ready", bus.b_ready, w == 1);

                if (w >= 0) begin
                    s1 = w ? bus.b_o1sel  : bus.a_o1sel;
                    s2 = w ? bus.b_o2sel  : bus.a_o2sel;
                    f  = w ? bus.b_funsel : bus.a_funsel;
                    rs = w ? bus.b_rsel   : bus.a_rsel;
                    ts = w ? bus.b_tsel   : bus.a_tsel;
                    wd = w ? bus.b_wdata  : bus.a_wdata;
`ifdef RF_ARB_LOCK_EN
                    lk = w ? bus.b_lock : bus.a_lock;
`else
                    lk = 1'b0;
`endif
                    // reads see all earlier writes, not this command's own write
                    rq.push_back('{due: cyc + 3, own_b: (w == 1), o1: sb_regs[s1], o2: sb_regs[s2]});
                    for (int k = 0; k < 4; k++) begin
                        if (rs[3-k]) sb_regs[4+k] = apply_fun(f, sb_regs[4+k], wd);
                        if (ts[3-k]) sb_regs[k]   = apply_fun(f, sb_regs[k], wd);
                    end
                    e_o1sel = s1; e_o2sel = s2; e_fun = f; e_rsel = rs; e_tsel = ts; e_i = wd;
                    last_b = (w == 1);
                    win_log.push_back(w);
                    lock_own = lk ? w : -1;
                end else begin
                    e_rsel = '0;
                    e_tsel = '0;
                    lock_own = -1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit to_b, input bit v, input logic [2:0] o1, input logic [2:0] o2,
                         input logic [1:0] f, input logic [3:0] rs, input logic [3:0] ts,
                         input logic [7:0] wd, input bit lk);
        if (!to_b) begin
            bus.a_valid = v; bus.a_o1sel = o1; bus.a_o2sel = o2; bus.a_funsel = f;
            bus.a_rsel = rs; bus.a_tsel = ts; bus.a_wdata = wd;
`ifdef RF_ARB_LOCK_EN
            bus.a_lock = lk;
`endif
        end else begin
            bus.b_valid = v; bus.b_o1sel = o1; bus.b_o2sel = o2; bus.b_funsel = f;
            bus.b_rsel = rs; bus.b_tsel = ts; bus.b_wdata = wd;
`ifdef RF_ARB_LOCK_EN
            bus.b_lock = lk;
`endif
        end
    endtask

    task automatic idle(input bit to_b);
        drive(to_b, 1'b0, 3'd0, 3'd0, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
    endtask

    task automatic check_log(input string name, input int got[$], input int exp[$]);
        check({name, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(name, got[i], exp[i]);
    endtask

    initial begin
        idle(1'b0);
        idle(1'b1);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Write R1 = 5A, then read it back through O1
        drive(1'b0, 1'b1, 3'd0, 3'd0, 2'b01, 4'b1000, 4'b0000, 8'h5A, 1'b0);
        tick();
        check("t1 rf_rsel after write", bus.rf_rsel, 4'b1000);
        check("t1 rf_i after write", bus.rf_i, 8'h5A);
        drive(1'b0, 1'b1, 3'b100, 3'b000, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick();
        idle(1'b0);
        check("t1 rf_o1sel read", bus.rf_o1sel, 3'b100);
        tick();
        check("t1 rf_rsel idle", bus.rf_rsel, 4'b0000);
        tick();
        @(negedge clk);
        check("t1 rsp_a_valid", bus.rsp_a_valid, 1'b1);
        check("t1 rsp_o1", bus.rsp_o1, 8'h5A);

        // Only B valid for 4 cycles
        tick();
        win_log.delete();
        rsp_log.delete();
        drive(1'b1, 1'b1, 3'b110, 3'b010, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        repeat (4) tick();
        idle(1'b1);
        repeat (3) tick();
        check_log("t3 grants", win_log, '{1, 1, 1, 1});
        check_log("t3 rsps", rsp_log, '{1, 1, 1, 1});

        // Both valid continuously: alternate starting with A
        win_log.delete();
        rsp_log.delete();
        drive(1'b0, 1'b1, 3'b100, 3'b000, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 3'b101, 3'b001, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        repeat (4) tick();
        idle(1'b0);
        idle(1'b1);
        repeat (3) tick();
        check_log("t2 grants", win_log, '{0, 1, 0, 1});
        check_log("t2 rsps", rsp_log, '{0, 1, 0, 1});

        // B writes R2 = 33, A reads it on O2 the very next cycle
        drive(1'b1, 1'b1, 3'd0, 3'd0, 2'b01, 4'b0100, 4'b0000, 8'h33, 1'b0);
        tick();
        idle(1'b1);
        drive(1'b0, 1'b1, 3'b000, 3'b101, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick();
        idle(1'b0);
        tick();
        tick();
        @(negedge clk);
        check("t4 rsp_a_valid", bus.rsp_a_valid, 1'b1);
        check("t4 rsp_o2", bus.rsp_o2, 8'h33);

        // Also exercise T-register increment: load T3 = 7F then increment it
        tick();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 2'b01, 4'b0000, 4'b0010, 8'h7F, 1'b0);
        tick();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 2'b10, 4'b0000, 4'b0010, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b1, 3'b010, 3'b100, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick();
        idle(1'b0);
        tick();
        tick();
        @(negedge clk);
        check("t6 rsp_o1 inc", bus.rsp_o1, 8'h80);
        check("t6 rsp_o2 R1", bus.rsp_o2, 8'h5A);

        // Reset while two reads are in flight
        tick();
        drive(1'b0, 1'b1, 3'b100, 3'b101, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick();
        idle(1'b0);
        drive(1'b1, 1'b1, 3'b101, 3'b100, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick();
        idle(1'b1);
        rst = 1'b1;
        rsp_log.delete();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("t5 rsp after reset", rsp_log.size(), 0);
        check("t5 rf_rsel", bus.rf_rsel, 4'b0000);
        check("t5 rf_tsel", bus.rf_tsel, 4'b0000);
        win_log.delete();
        drive(1'b0, 1'b1, 3'b000, 3'b000, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 3'b000, 3'b000, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick();
        idle(1'b0);
        idle(1'b1);
        repeat (3) tick();
        check_log("t5 first grant", win_log, '{0});

`ifdef RF_ARB_LOCK_EN
        // A holds lock across 3 commands while B stays valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        win_log.delete();
        drive(1'b1, 1'b1, 3'b001, 3'b010, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 3'b100, 3'b000, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b1, 3'b101, 3'b000, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b1, 3'b110, 3'b000, 2'b00, 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick();
        idle(1'b0);
        tick();
        idle(1'b1);
        repeat (3) tick();
        check_log("lock grants", win_log, '{0, 0, 0, 1});
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
